// File: rtl/dsp_seq_pkg.sv
// Shared types and DSP48 OPMODE encodings for the MAC job sequencer.
package dsp_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FEED  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_HOLD  = 2'd3
  } seq_state_t;

  localparam logic [7:0] OPM_IDLE = 8'h00;
  localparam logic [7:0] OPM_LOAD = 8'h01;  // X=M, Z=0
  localparam logic [7:0] OPM_ACC  = 8'h09;  // X=M, Z=P

  // The first issue of a job restarts the accumulator, every later one adds to P.
  function automatic logic [7:0] feed_opmode(input logic seen);
    return seen ? OPM_ACC : OPM_LOAD;
  endfunction

endpackage

// File: rtl/dsp_seq_delay.sv
// Fixed-depth delay line that aligns OPMODE with its operands at the DSP post-adder.
module dsp_seq_delay #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  generate
    if (DEPTH == 0) begin : g_pass
      assign o_q = i_d;
    end else begin : g_line
      logic [WIDTH-1:0] r_line [DEPTH];

      always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
          for (int i = 0; i < DEPTH; i++) r_line[i] <= '0;
        end else begin
          r_line[0] <= i_d;
          for (int i = 1; i < DEPTH; i++) r_line[i] <= r_line[i-1];
        end
      end

      assign o_q = r_line[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/dsp_mac_sequencer.sv
// Sequences an N-pair multiply-accumulate job through a pipelined DSP48 slice
// and holds the accumulated P value until the consumer takes it.
module dsp_mac_sequencer
  import dsp_seq_pkg::*;
#(
  parameter int WIDTH_A  = 18,
  parameter int WIDTH_P  = 48,
  parameter int LEN_W    = 8,
  parameter int PIPE_LAT = 3,
  parameter int OP_DLY   = 1
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic               start,
  input  logic [LEN_W-1:0]   len,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [WIDTH_A-1:0] s_a,
  input  logic [WIDTH_A-1:0] s_b,
  output logic [WIDTH_A-1:0] dsp_a,
  output logic [WIDTH_A-1:0] dsp_b,
  output logic [7:0]         dsp_opmode,
  output logic               dsp_ce,
  input  logic [WIDTH_P-1:0] dsp_p,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [WIDTH_P-1:0] res_data,
  output logic               busy,
  output logic               err
);

  localparam int DRN_W = $clog2(PIPE_LAT + 1) + 1;

  seq_state_t         r_state;
  logic [LEN_W-1:0]   r_cnt;
  logic [DRN_W-1:0]   r_drn;
  logic               r_seen;
  logic               r_s_ready;
  logic               r_ce;
  logic               r_busy;
  logic               r_err;
  logic               r_res_valid;
  logic [WIDTH_A-1:0] r_dsp_a;
  logic [WIDTH_A-1:0] r_dsp_b;
  logic [7:0]         r_opm_issue;
  logic [WIDTH_P-1:0] r_res_data;
  logic [7:0]         w_opm_dly;
  logic               w_hs;

  assign w_hs = s_valid & r_s_ready;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_drn       <= '0;
      r_seen      <= 1'b0;
      r_s_ready   <= 1'b0;
      r_ce        <= 1'b0;
      r_busy      <= 1'b0;
      r_err       <= 1'b0;
      r_res_valid <= 1'b0;
      r_dsp_a     <= '0;
      r_dsp_b     <= '0;
      r_opm_issue <= OPM_IDLE;
      r_res_data  <= '0;
    end else begin
      r_err <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_dsp_a     <= '0;
          r_dsp_b     <= '0;
          r_opm_issue <= OPM_IDLE;
          if (start) begin
            if (len != '0) begin
              r_state   <= ST_FEED;
              r_cnt     <= len;
              r_seen    <= 1'b0;
              r_s_ready <= 1'b1;
              r_ce      <= 1'b1;
              r_busy    <= 1'b1;
            end else begin
              r_err <= 1'b1;
            end
          end
        end

        // Stall cycles still issue a zero product so the pipeline keeps advancing.
        ST_FEED: begin
          r_opm_issue <= feed_opmode(r_seen);
          if (w_hs) begin
            r_dsp_a <= s_a;
            r_dsp_b <= s_b;
            r_seen  <= 1'b1;
            r_cnt   <= r_cnt - LEN_W'(1);
            if (r_cnt == LEN_W'(1)) begin
              r_state   <= ST_DRAIN;
              r_s_ready <= 1'b0;
              r_drn     <= DRN_W'(PIPE_LAT);
            end
          end else begin
            r_dsp_a <= '0;
            r_dsp_b <= '0;
          end
        end

        // PIPE_LAT cycles flush the last product into P, plus one to sample it
        // since dsp_a/dsp_b add a register ahead of the DSP input stage.
        ST_DRAIN: begin
          r_dsp_a     <= '0;
          r_dsp_b     <= '0;
          r_opm_issue <= OPM_ACC;
          if (r_drn == '0) begin
            r_res_data  <= dsp_p;
            r_res_valid <= 1'b1;
            r_ce        <= 1'b0;
            r_opm_issue <= OPM_IDLE;
            r_state     <= ST_HOLD;
          end else begin
            r_drn <= r_drn - DRN_W'(1);
          end
        end

        ST_HOLD: begin
          r_opm_issue <= OPM_IDLE;
          if (res_ready) begin
            r_res_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

  dsp_seq_delay #(
    .DEPTH (OP_DLY),
    .WIDTH (8)
  ) u_opm_dly (
    .CLK   (CLK),
    .RST_N (RST_N),
    .i_d   (r_opm_issue),
    .o_q   (w_opm_dly)
  );

  assign s_ready    = r_s_ready;
  assign dsp_a      = r_dsp_a;
  assign dsp_b      = r_dsp_b;
  assign dsp_opmode = w_opm_dly;
  assign dsp_ce     = r_ce;
  assign res_valid  = r_res_valid;
  assign res_data   = r_res_data;
  assign busy       = r_busy;
  assign err        = r_err;

endmodule

// File: tb/tb_dsp_mac_sequencer.sv
// Bench for dsp_mac_sequencer: drives jobs into a behavioural DSP48A1 slice and
// compares each result with a sum-of-products reference computed in the bench.
module tb_dsp_mac_sequencer;

  localparam int WIDTH_A  = 18;
  localparam int WIDTH_P  = 48;
  localparam int LEN_W    = 8;
  localparam int PIPE_LAT = 3;
  localparam int OP_DLY   = 1;
  localparam int AHALF    = 1 << (WIDTH_A - 1);

  logic               clk = 1'b0;
  logic               RST_N = 1'b0;
  logic               start = 1'b0;
  logic [LEN_W-1:0]   len = '0;
  logic               s_valid = 1'b0;
  logic               s_ready;
  logic [WIDTH_A-1:0] s_a = '0;
  logic [WIDTH_A-1:0] s_b = '0;
  logic [WIDTH_A-1:0] dsp_a;
  logic [WIDTH_A-1:0] dsp_b;
  logic [7:0]         dsp_opmode;
  logic               dsp_ce;
  logic [WIDTH_P-1:0] dsp_p;
  logic               res_valid;
  logic               res_ready = 1'b0;
  logic [WIDTH_P-1:0] res_data;
  logic               busy;
  logic               err;

  int n_cmp = 0;
  int n_mis = 0;
  int cyc   = 0;
  int job_a [16];
  int job_b [16];
  int job_stall [16];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dsp_mac_sequencer #(
    .WIDTH_A  (WIDTH_A),
    .WIDTH_P  (WIDTH_P),
    .LEN_W    (LEN_W),
    .PIPE_LAT (PIPE_LAT),
    .OP_DLY   (OP_DLY)
  ) dut (
    .CLK        (clk),
    .RST_N      (RST_N),
    .start      (start),
    .len        (len),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_a        (s_a),
    .s_b        (s_b),
    .dsp_a      (dsp_a),
    .dsp_b      (dsp_b),
    .dsp_opmode (dsp_opmode),
    .dsp_ce     (dsp_ce),
    .dsp_p      (dsp_p),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_data   (res_data),
    .busy       (busy),
    .err        (err)
  );

  // Behavioural DSP48A1 stand-in: A0/B0 bypassed, A1/B1, M, P and OPMODE registered.
  logic signed [WIDTH_A-1:0]   d_a1 = '0;
  logic signed [WIDTH_A-1:0]   d_b1 = '0;
  logic signed [2*WIDTH_A-1:0] d_m  = '0;
  logic [7:0]                  d_opm = '0;
  logic signed [WIDTH_P-1:0]   d_p  = '0;

  always @(posedge clk) begin
    if (dsp_ce) begin
      d_a1  <= dsp_a;
      d_b1  <= dsp_b;
      d_m   <= d_a1 * d_b1;
      d_opm <= dsp_opmode;
      case (d_opm)
        8'h01:   d_p <= WIDTH_P'(d_m);
        8'h09:   d_p <= d_p + WIDTH_P'(d_m);
        default: d_p <= '0;
      endcase
    end
  end
  assign dsp_p = d_p;

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic set_pair(input int k, input int a, input int b, input int st);
    job_a[k]     = a;
    job_b[k]     = b;
    job_stall[k] = st;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, "_s_ready"}, s_ready, 0);
    check_val({tag, "_dsp_a"}, dsp_a, 0);
    check_val({tag, "_dsp_b"}, dsp_b, 0);
    check_val({tag, "_opmode"}, dsp_opmode, 0);
    check_val({tag, "_ce"}, dsp_ce, 0);
    check_val({tag, "_res_valid"}, res_valid, 0);
    check_val({tag, "_res_data"}, res_data, 0);
    check_val({tag, "_busy"}, busy, 0);
    check_val({tag, "_err"}, err, 0);
  endtask

  // Reference: result is the plain sum of signed products modulo 2^WIDTH_P,
  // arriving len + stalls + PIPE_LAT + 1 cycles after start is sampled.
  task automatic run_job(input int L, input int hold_cyc, input bit poke_start);
    longint             acc;
    int                 stalls;
    int                 t0;
    bit                 got;
    logic [WIDTH_P-1:0] exp_p;
    acc    = 0;
    stalls = 0;
    for (int k = 0; k < L; k++) begin
      acc    += longint'(job_a[k]) * longint'(job_b[k]);
      stalls += job_stall[k];
    end
    exp_p = acc[WIDTH_P-1:0];

    start = 1'b1;
    len   = LEN_W'(L);
    tick();
    start = 1'b0;
    t0    = cyc;
    check_val("busy_on_start", busy, 1);

    for (int k = 0; k < L; k++) begin
      for (int s = 0; s < job_stall[k]; s++) begin
        s_valid = 1'b0;
        s_a     = WIDTH_A'($urandom);
        s_b     = WIDTH_A'($urandom);
        check_val("s_ready_stall", s_ready, 1);
        check_val("ce_stall", dsp_ce, 1);
        tick();
      end
      s_valid = 1'b1;
      s_a     = WIDTH_A'(job_a[k]);
      s_b     = WIDTH_A'(job_b[k]);
      if (poke_start && k == 0) begin
        start = 1'b1;
        len   = LEN_W'(0);
      end
      check_val("s_ready_feed", s_ready, 1);
      check_val("ce_feed", dsp_ce, 1);
      tick();
      if (poke_start && k == 0) begin
        start = 1'b0;
        check_val("err_start_busy", err, 0);
        check_val("busy_start_busy", busy, 1);
      end
    end
    s_valid = 1'b0;
    check_val("s_ready_after_last", s_ready, 0);

    got = 1'b0;
    for (int c = 0; c < 64 && !got; c++) begin
      if (res_valid) got = 1'b1;
      else tick();
    end
    check_val("res_valid_timeout", got, 1);
    check_val("latency", cyc - t0, L + stalls + PIPE_LAT + 1);
    check_val("res_data", res_data, exp_p);
    check_val("ce_hold", dsp_ce, 0);

    for (int h = 0; h < hold_cyc; h++) begin
      tick();
      check_val("hold_valid", res_valid, 1);
      check_val("hold_data", res_data, exp_p);
      check_val("hold_ce", dsp_ce, 0);
    end

    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check_val("valid_drop", res_valid, 0);
    check_val("busy_drop", busy, 0);
    check_val("idle_opmode", dsp_opmode, 0);
    check_val("idle_dsp_a", dsp_a, 0);
    check_val("idle_ce", dsp_ce, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    repeat (3) tick();
    check_all_zero("reset");
    RST_N = 1'b1;
    tick();

    // Single pair, no stalls.
    set_pair(0, 10, 15, 0);
    run_job(1, 0, 1'b0);

    // Four pairs with a long result back-pressure, then a job that must not see old P.
    set_pair(0, 1, 2, 0);
    set_pair(1, 3, 4, 0);
    set_pair(2, 5, 6, 0);
    set_pair(3, 7, 8, 0);
    run_job(4, 5, 1'b0);
    set_pair(0, 3, 3, 0);
    run_job(1, 0, 1'b0);

    // Stalls before and between pairs, with a start pulse while busy.
    set_pair(0, 10, 15, 2);
    set_pair(1, 2, 3, 1);
    set_pair(2, 4, 4, 0);
    run_job(3, 1, 1'b1);

    // Zero-length request is rejected.
    start = 1'b1;
    len   = '0;
    tick();
    start = 1'b0;
    check_val("err_pulse", err, 1);
    check_val("err_busy", busy, 0);
    tick();
    check_val("err_clear", err, 0);
    check_val("err_busy_after", busy, 0);

    // Asynchronous reset in the middle of a four-pair job.
    start = 1'b1;
    len   = LEN_W'(4);
    tick();
    start = 1'b0;
    for (int k = 0; k < 2; k++) begin
      s_valid = 1'b1;
      s_a     = WIDTH_A'(100 + k);
      s_b     = WIDTH_A'(7);
      tick();
    end
    #2;
    RST_N = 1'b0;
    #1;
    check_all_zero("midreset");
    s_valid = 1'b0;
    tick();
    RST_N = 1'b1;
    for (int c = 0; c < 8; c++) begin
      check_val("no_valid_after_abort", res_valid, 0);
      tick();
    end
    set_pair(0, -2, 5, 0);
    run_job(1, 0, 1'b0);

    // Randomized jobs over the full signed operand range.
    for (int j = 0; j < 20; j++) begin
      int L;
      L = int'($urandom_range(1, 12));
      for (int k = 0; k < L; k++) begin
        set_pair(k, int'($urandom_range(0, 2*AHALF-1)) - AHALF,
                    int'($urandom_range(0, 2*AHALF-1)) - AHALF,
                    int'($urandom_range(0, 2)));
      end
      run_job(L, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
